// File: rtl/shift_sub_divider_pkg.sv
// ---------------------------------------------------------------------------
// shift_sub_div_pkg
// Shared types and helpers for the restoring shift-subtract divider.
//   state_t        : divider FSM states (IDLE, CALC, DONE), 2 bits
//   step_cnt_width : width of the step counter, which must hold the value N
// No ports (package).
// ---------------------------------------------------------------------------
package shift_sub_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is loaded with N and counts down to 0, so it needs enough
  // bits to represent N itself.
  function automatic int step_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_sub_divider_if.sv
// ---------------------------------------------------------------------------
// shift_sub_divider_if
// Start/busy/done handshake and operand/result bus of the divider.
//   start       : request a division (master -> slave)
//   dividend    : N-bit unsigned dividend (master -> slave)
//   divisor     : N-bit unsigned divisor (master -> slave)
//   busy        : divider is working, high in CALC and DONE (slave -> master)
//   done        : one-cycle pulse, results valid (slave -> master)
//   quotient    : N-bit unsigned quotient (slave -> master)
//   remainder   : N-bit unsigned remainder (slave -> master)
//   div_by_zero : last result came from a zero divisor (slave -> master)
// Modports: master (controller side), slave (divider side).
// ---------------------------------------------------------------------------
interface shift_sub_divider_if #(
  parameter int N = 4
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/shift_sub_divider_step_counter.sv
// ---------------------------------------------------------------------------
// div_step_counter
// Loadable down-counter that sequences the divider iterations.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load data_in (takes priority over en)
//   en       : decrement by one, saturating at 0
//   data_in  : value to load
//   data_out : current count
//   c_end    : high when the count is 0
// ---------------------------------------------------------------------------
module div_step_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             c_end
);

  // Count register: reset clears it, load wins over enable, and the
  // decrement stops at zero so a stray enable cannot wrap the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end else if (en && (data_out != '0)) begin
      data_out <= data_out - WIDTH'(1);
    end
  end

  assign c_end = (data_out == '0);

endmodule

// File: rtl/shift_sub_divider.sv
// ---------------------------------------------------------------------------
// shift_sub_divider
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any division in progress
//   bus : shift_sub_divider_if.slave (start/dividend/divisor in,
//         busy/done/quotient/remainder/div_by_zero out)
// Optional feature macro: SHIFT_SUB_DIV_ZERO_DETECT_EN
//   defined   : a zero divisor skips the iterations and reports div_by_zero
//   undefined : a zero divisor runs the normal iterations, div_by_zero = 0
// The interface parameter N must match this module's N.
// ---------------------------------------------------------------------------
module shift_sub_divider
  import shift_sub_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_sub_divider_if.slave  bus
);

  localparam int CNT_W = step_cnt_width(N);

  state_t           state;
  // The partial remainder A is N+1 bits wide conceptually, but after each
  // restore step it is always below the divisor, so its top bit is always
  // 0 and only the low N bits are stored; the trial subtraction below is
  // still done in N+1 bits.
  logic [N-1:0]     a_reg;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     divisor_reg;
  logic [N-1:0]     quotient_reg;
  logic [N-1:0]     remainder_reg;
  logic             busy_reg;
  logic             done_reg;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
  logic             dbz_reg;
  logic             fast_pending;
`endif

  logic [N:0]       a_shift;
  logic [N:0]       trial;
  logic [N-1:0]     a_next;
  logic [N-1:0]     q_next;
  logic             accept;
  logic             last_step;
  logic [CNT_W-1:0] step_count;
  logic             step_zero;

  // One restoring iteration: shift {A,Q} left, trial-subtract the divisor
  // from A, and keep the difference only if it did not go negative.
  always_comb begin
    a_shift = {a_reg, q_reg[N-1]};
    trial   = a_shift - {1'b0, divisor_reg};
    if (trial[N]) begin
      a_next = a_shift[N-1:0];
      q_next = {q_reg[N-2:0], 1'b0};
    end else begin
      a_next = trial[N-1:0];
      q_next = {q_reg[N-2:0], 1'b1};
    end
  end

  assign accept    = (state == IDLE) && bus.start;
  // The iteration that brings the counter from 1 to 0 is the last one; the
  // zero check only guards against an impossible empty CALC.
  assign last_step = (step_count == CNT_W'(1)) || step_zero;

  div_step_counter #(
    .WIDTH (CNT_W)
  ) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (state == CALC),
    .data_in  (CNT_W'(N)),
    .data_out (step_count),
    .c_end    (step_zero)
  );

  // Control FSM and datapath registers. Results are written only when a
  // division finishes, so they stay stable through the next operation
  // until its own done pulse. Reset clears everything and wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      q_reg         <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
      dbz_reg       <= 1'b0;
      fast_pending  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg       <= '0;
            q_reg       <= bus.dividend;
            divisor_reg <= bus.divisor;
            busy_reg    <= 1'b1;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
            // Zero divisor skips CALC; the result is posted on the way
            // out of DONE so it arrives together with its done pulse.
            if (bus.divisor == '0) begin
              state        <= DONE;
              fast_pending <= 1'b1;
            end else begin
              state        <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end

        CALC: begin
          a_reg <= a_next;
          q_reg <= q_next;
          if (last_step) begin
            state         <= DONE;
            quotient_reg  <= q_next;
            remainder_reg <= a_next;
            done_reg      <= 1'b1;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
            dbz_reg       <= 1'b0;
`endif
          end
        end

        DONE: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
          done_reg     <= fast_pending;
          fast_pending <= 1'b0;
          if (fast_pending) begin
            quotient_reg  <= '1;
            remainder_reg <= q_reg;
            dbz_reg       <= 1'b1;
          end
`else
          done_reg <= 1'b0;
`endif
        end

        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
  assign bus.div_by_zero = dbz_reg;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
// ---------------------------------------------------------------------------
// tb_shift_sub_divider
// Self-checking bench for shift_sub_divider with N = 4.
// Honours SHIFT_SUB_DIV_ZERO_DETECT_EN for the zero-divisor expectations.
// ---------------------------------------------------------------------------
module tb_shift_sub_divider;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    int           exp_q;
    int           exp_r;
    int           exp_dbz;
    int           exp_lat;
    int           exp_busy;
    string        tag;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[5];

  shift_sub_divider_if #(.N(N)) bus ();

  shift_sub_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports any difference.
  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Presents operands with start for one accepting edge; returns at the
  // falling edge just after that edge with start dropped.
  task automatic apply_stimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Runs one table vector, measuring latency and busy time.
  task automatic run_vector(input vec_t v);
    int k;
    int busy_cnt;
    bit got;
    apply_stimulus(v.dividend, v.divisor);
    k        = 0;
    busy_cnt = bus.busy ? 1 : 0;
    got      = bus.done;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
    end
    check_output({v.tag, "_latency"}, got ? k : -1, v.exp_lat);
    check_output({v.tag, "_quotient"}, int'(bus.quotient), v.exp_q);
    check_output({v.tag, "_remainder"}, int'(bus.remainder), v.exp_r);
    check_output({v.tag, "_div_by_zero"}, int'(bus.div_by_zero), v.exp_dbz);
    check_output({v.tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
    @(negedge clk);
    check_output({v.tag, "_done_pulse_end"}, int'(bus.done), 0);
    check_output({v.tag, "_busy_end"}, int'(bus.busy), 0);
  endtask

  initial begin
    int k;
    int done_cnt;
    int first_k;

    checks = 0;
    errors = 0;

    vecs[0] = '{4'd13, 4'd3, 4, 1, 0, 4, 5, "div_13_3"};
    vecs[1] = '{4'd15, 4'd1, 15, 0, 0, 4, 5, "div_15_1"};
    vecs[2] = '{4'd5,  4'd7, 0, 5, 0, 4, 5, "div_5_7"};
    vecs[3] = '{4'd0,  4'd5, 0, 0, 0, 4, 5, "div_0_5"};
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
    vecs[4] = '{4'd9,  4'd0, 15, 9, 1, 1, 1, "div_9_0"};
`else
    vecs[4] = '{4'd9,  4'd0, 15, 9, 0, 4, 5, "div_9_0"};
`endif

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_busy", int'(bus.busy), 0);
    check_output("reset_done", int'(bus.done), 0);
    check_output("reset_quotient", int'(bus.quotient), 0);
    check_output("reset_remainder", int'(bus.remainder), 0);
    check_output("reset_div_by_zero", int'(bus.div_by_zero), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_vector(vecs[i]);
    end

    // start pulsed mid-calculation with other operands is ignored.
    apply_stimulus(4'd12, 4'd5);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd7;
    bus.divisor  = 4'd2;
    @(negedge clk);
    bus.start    = 1'b0;
    k        = 2;
    done_cnt = 0;
    first_k  = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      k++;
      if (bus.done) begin
        done_cnt++;
        if (first_k < 0) first_k = k;
      end
    end
    check_output("ignored_start_done_count", done_cnt, 1);
    check_output("ignored_start_latency", first_k, 4);
    check_output("ignored_start_quotient", int'(bus.quotient), 2);
    check_output("ignored_start_remainder", int'(bus.remainder), 2);
    check_output("ignored_start_busy_end", int'(bus.busy), 0);

    // Reset mid-operation aborts without a done pulse.
    apply_stimulus(4'd14, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_busy", int'(bus.busy), 0);
    check_output("abort_done", int'(bus.done), 0);
    check_output("abort_quotient", int'(bus.quotient), 0);
    check_output("abort_remainder", int'(bus.remainder), 0);
    check_output("abort_div_by_zero", int'(bus.div_by_zero), 0);
    rst      = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    check_output("abort_stays_idle", done_cnt, 0);
    run_vector('{4'd14, 4'd3, 4, 2, 0, 4, 5, "div_14_3_after_abort"});

    // Back-to-back with start held high: second request accepted at E6.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd10;
    bus.divisor  = 4'd3;
    @(negedge clk);
    bus.dividend = 4'd8;
    bus.divisor  = 4'd2;
    check_output("b2b_busy_e0", int'(bus.busy), 1);
    repeat (4) @(negedge clk);
    check_output("b2b_first_done", int'(bus.done), 1);
    check_output("b2b_first_quotient", int'(bus.quotient), 3);
    check_output("b2b_first_remainder", int'(bus.remainder), 1);
    @(negedge clk);
    check_output("b2b_gap_busy", int'(bus.busy), 0);
    check_output("b2b_gap_done", int'(bus.done), 0);
    @(negedge clk);
    bus.start = 1'b0;
    check_output("b2b_second_accept_busy", int'(bus.busy), 1);
    check_output("b2b_hold_quotient_e6", int'(bus.quotient), 3);
    repeat (3) @(negedge clk);
    check_output("b2b_hold_quotient_e9", int'(bus.quotient), 3);
    check_output("b2b_no_early_done", int'(bus.done), 0);
    @(negedge clk);
    check_output("b2b_second_done", int'(bus.done), 1);
    check_output("b2b_second_quotient", int'(bus.quotient), 4);
    check_output("b2b_second_remainder", int'(bus.remainder), 0);
    repeat (2) @(negedge clk);
    check_output("b2b_end_busy", int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
